// File: rtl/barrel_ctrl.sv
// barrel_ctrl: round-robin sequencer feeding one shared right-rotate barrel shifter in MAX_STEP chunks.
// Optional BARREL_CTRL_LEFT_EN adds req_dir so requesters may ask for left rotations.
module barrel_ctrl #(
    parameter int DATA_W   = 8,
    parameter int SEL_W    = 3,
    parameter int MAX_STEP = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_data,
    input  logic [2*SEL_W-1:0]  req_amt,
`ifdef BARREL_CTRL_LEFT_EN
    input  logic [1:0]          req_dir,
`endif
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_id,
    output logic                brl_load,
    output logic [SEL_W-1:0]    brl_sel,
    output logic [DATA_W-1:0]   brl_data,
    input  logic [DATA_W-1:0]   brl_q,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
    localparam logic [SEL_W-1:0] MAX_S = SEL_W'(MAX_STEP);
    state_t             state;
    logic [DATA_W-1:0]  d_reg;
    logic [SEL_W-1:0]   rem, step, amt_sel, amt_in;
    logic               id_reg, rr_last, first, grant, accept;
    assign grant   = (req_valid == 2'b11) ? ~rr_last : req_valid[1];
    assign accept  = (state == IDLE) && (|req_valid);
    assign amt_sel = grant ? req_amt[2*SEL_W-1:SEL_W] : req_amt[SEL_W-1:0];
`ifdef BARREL_CTRL_LEFT_EN
    // Left by n equals right by -n modulo DATA_W; the SEL_W-bit wrap does the modulo.
    assign amt_in  = req_dir[grant] ? SEL_W'(0) - amt_sel : amt_sel;
`else
    assign amt_in  = amt_sel;
`endif
    assign step = (rem > MAX_S) ? MAX_S : rem;
    // Gating with reset_n keeps the combinational grant quiet while reset is held.
    assign req_ready  = (accept && reset_n) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign brl_load   = (state == SHIFT) && first;
    assign brl_sel    = (state == SHIFT) ? step : '0;
    assign brl_data   = (state == SHIFT) ? d_reg : '0;
    assign resp_valid = (state == RESP);
    assign resp_data  = (state == RESP) ? brl_q : '0;
    assign resp_id    = (state == RESP) && id_reg;
    assign busy       = (state != IDLE);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            d_reg   <= '0;
            rem     <= '0;
            id_reg  <= 1'b0;
            rr_last <= 1'b1;
            first   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    d_reg   <= grant ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
                    rem     <= amt_in;
                    id_reg  <= grant;
                    rr_last <= grant;
                    first   <= 1'b1;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    rem   <= rem - step;
                    first <= 1'b0;
                    if (rem == step) state <= RESP;
                end
                RESP: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_barrel_ctrl.sv
// tb_barrel_ctrl: directed and random transactions against a rotate/round-robin reference model.
module tb_barrel_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [15:0] req_data = '0;
    logic [5:0]  req_amt = '0;
`ifdef BARREL_CTRL_LEFT_EN
    logic [1:0]  req_dir = 2'b00;
`endif
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [7:0]  resp_data;
    logic        resp_id;
    logic        brl_load;
    logic [2:0]  brl_sel;
    logic [7:0]  brl_data;
    logic [7:0]  brl_q = '0;
    logic        busy;
    int          errors = 0;
    int          checks = 0;
    int          rr_last = 1;

    always #5 clk = ~clk;

    barrel_ctrl #(.DATA_W(8), .SEL_W(3), .MAX_STEP(3)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_amt(req_amt),
`ifdef BARREL_CTRL_LEFT_EN
        .req_dir(req_dir),
`endif
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .brl_load(brl_load), .brl_sel(brl_sel), .brl_data(brl_data),
        .brl_q(brl_q), .busy(busy)
    );

    function automatic logic [7:0] rotr(input logic [7:0] d, input int a);
        logic [15:0] t;
        t = {d, d} >> (a % 8);
        return t[7:0];
    endfunction

    // Behavioural shifter the controller drives.
    always @(posedge clk) brl_q <= rotr(brl_load ? brl_data : brl_q, int'(brl_sel));

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_resp_id"}, resp_id, 0);
        chk({tag, "_brl_load"}, brl_load, 0);
        chk({tag, "_brl_sel"}, brl_sel, 0);
        chk({tag, "_brl_data"}, brl_data, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // One full accept/shift/response sequence; requests stay at vm throughout.
    task automatic txn(input logic [1:0] vm, input logic [7:0] d0, input logic [7:0] d1,
                       input int a0, input int a1, input logic [1:0] dir, input int hold);
        int g, amt, n, s;
        logic [7:0] d, res;
        req_valid = vm;
        req_data  = {d1, d0};
        req_amt   = {3'(a1), 3'(a0)};
`ifdef BARREL_CTRL_LEFT_EN
        req_dir   = dir;
`endif
        g   = (vm == 2'b11) ? (rr_last == 0 ? 1 : 0) : (vm[1] ? 1 : 0);
        d   = g ? d1 : d0;
        amt = (g ? a1 : a0) % 8;
        if (dir[g]) amt = (8 - amt) % 8;
        n   = (amt == 0) ? 1 : (amt + 2) / 3;
        res = rotr(d, amt);
        @(negedge clk);
        chk("grant", req_ready, 2'b01 << g);
        chk("busy_idle", busy, 0);
        @(posedge clk); #1;
        rr_last = g;
        for (int k = 0; k < n; k++) begin
            s = (k < n - 1) ? 3 : amt - 3 * (n - 1);
            @(negedge clk);
            chk("shift_load", brl_load, (k == 0) ? 1 : 0);
            chk("shift_sel", brl_sel, s);
            chk("shift_data", brl_data, d);
            chk("shift_busy", busy, 1);
            chk("shift_ready", req_ready, 0);
            chk("shift_resp_valid", resp_valid, 0);
            @(posedge clk); #1;
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            chk("resp_valid", resp_valid, 1);
            chk("resp_data", resp_data, res);
            chk("resp_id", resp_id, g);
            chk("resp_hold_shifter", {brl_load, brl_sel}, 0);
            chk("resp_ready_block", req_ready, 0);
            chk("resp_busy", busy, 1);
            if (h == hold) resp_ready = 1'b1;
            @(posedge clk); #1;
        end
        resp_ready = 1'b0;
    endtask

    initial begin
        int vm, a0, a1, hold;
        logic [1:0] dir;
        req_valid = 2'b11;
        #3;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        rr_last = 1;
        // Contention from reset: grants must alternate starting at requester 0.
        for (int i = 0; i < 4; i++) txn(2'b11, 8'h10 + 8'(i), 8'h20 + 8'(i), i, 7 - i, 2'b00, 0);
        txn(2'b01, 8'hB4, 8'h00, 5, 0, 2'b00, 0);
        txn(2'b10, 8'h00, 8'h3C, 0, 0, 2'b00, 0);
        txn(2'b01, 8'h01, 8'h00, 7, 0, 2'b00, 0);
        txn(2'b01, 8'h5A, 8'h00, 3, 0, 2'b00, 5);
        for (int i = 0; i < 25; i++) begin
            vm   = $urandom_range(1, 3);
            a0   = $urandom_range(0, 7);
            a1   = $urandom_range(0, 7);
            hold = $urandom_range(0, 3);
`ifdef BARREL_CTRL_LEFT_EN
            dir  = 2'($urandom_range(0, 3));
`else
            dir  = 2'b00;
`endif
            txn(2'(vm), 8'($urandom), 8'($urandom), a0, a1, dir, hold);
        end
`ifdef BARREL_CTRL_LEFT_EN
        txn(2'b01, 8'h81, 8'h00, 1, 0, 2'b01, 0);
`endif
        // Reset pulsed during the second SHIFT cycle of a 3-step rotation.
        req_valid = 2'b01;
        req_data  = 16'h0001;
        req_amt   = 6'd7;
`ifdef BARREL_CTRL_LEFT_EN
        req_dir   = 2'b00;
`endif
        @(posedge clk); #1;
        req_valid = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk); #1;
        chk_all_zero("held_reset");
        reset_n = 1'b1;
        rr_last = 1;
        txn(2'b11, 8'hC3, 8'h99, 2, 4, 2'b00, 0);
        req_valid = 2'b00;
        @(negedge clk);
        chk("final_idle", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/barrel_ctrl.md
Name: barrel_ctrl

Overview:
Sequencer and arbiter in front of one shared barrel (right-rotate) shifter. Two requesters submit {data, rotate amount}. The controller round-robin arbitrates between them and splits each rotation into steps of at most MAX_STEP positions. It drives the shifter's Load/sel/data_in over several cycles and returns the rotated word on a valid/ready response channel tagged with the requester id.

Parameters:
DATA_W, 8, word width; power of two, >= 4.
SEL_W, 3, log2(DATA_W); width of shifter select and of the amount field.
MAX_STEP, 3, largest rotate issued to the shifter in one cycle; 1..DATA_W-1.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester accept; one-hot or zero
req_data  in  2*DATA_W  requester i data at [i*DATA_W +: DATA_W]
req_amt  in  2*SEL_W  requester i right-rotate amount at [i*SEL_W +: SEL_W]
resp_valid  out  1  result valid
resp_ready  in  1  consumer accept
resp_data  out  DATA_W  rotated word
resp_id  out  1  requester that owns resp_data
brl_load  out  1  to shifter Load
brl_sel  out  SEL_W  to shifter sel
brl_data  out  DATA_W  to shifter data_in
brl_q  in  DATA_W  from shifter data_out (registered inside shifter)
busy  out  1  high in any state other than IDLE

Behaviour:
- Shifter contract: at each clk edge, data_out <= rotr(Load ? data_in : data_out, sel). brl_load=0 with brl_sel=0 holds the shifter.
- Reset (async assert, sync release): state=IDLE. All outputs 0 (req_ready=00, resp_valid=0, resp_data=0, resp_id=0, brl_load=0, brl_sel=0, brl_data=0, busy=0). rr_last=1, so requester 0 has first priority. Any in-flight operation is discarded with no response.
- States: IDLE, SHIFT, RESP.
- IDLE:
  - Grant = the only valid requester, or, if both are valid, the one != rr_last.
  - req_ready[grant]=1 combinationally in the same cycle; handshake completes when valid&ready.
  - On accept: latch data into d_reg, amt into rem, grant into id_reg and rr_last; set first=1; go to SHIFT.
  - No valid requests: stay in IDLE; brl_load=0, brl_sel=0.
- SHIFT:
  - step = min(rem, MAX_STEP). Drive brl_sel=step and brl_data=d_reg; brl_load=first.
  - Each cycle: rem <= rem-step; first <= 0.
  - If rem-step==0, go to RESP.
  - SHIFT lasts max(1, ceil(amt/MAX_STEP)) cycles. amt=0 gives exactly one cycle with load=1, sel=0.
- RESP:
  - brl_load=0, brl_sel=0 (shifter holds). resp_valid=1, resp_data=brl_q, resp_id=id_reg.
  - Stay in RESP until resp_ready=1, then go to IDLE.
  - resp_data and resp_id stay stable while resp_valid=1 and resp_ready=0.
- req_ready is 00 in SHIFT and RESP. There is no overlap: a new accept happens at the earliest in the cycle after the response handshake.
- Latency from accept edge to resp_valid=1: SHIFT cycle count + 0, i.e. resp_valid rises in the cycle after the last SHIFT cycle.
- Amount arithmetic is modulo DATA_W (SEL_W bits); rem never underflows.
- rr_last updates only on an accept.

Optional Feature:
Macro BARREL_CTRL_LEFT_EN.
- Defined:
  - Adds port req_dir, in, 2: per-requester direction, 1 = rotate left.
  - A left amount n is converted at accept to right amount (DATA_W-n) mod DATA_W before loading rem; left 0 gives right 0.
  - SHIFT cycle count is computed from the converted amount.
- Undefined: no req_dir port; all rotations are right rotations.

Test Plan:
(DATA_W=8, MAX_STEP=3)
- req0 data=0xB4 amt=5, resp_ready=1 -> 2 SHIFT cycles with brl_sel=3 (brl_load=1) then 2 (brl_load=0); resp_valid next cycle, resp_data=0xA5, resp_id=0.
- req1 data=0x3C amt=0 -> single SHIFT cycle with brl_load=1, brl_sel=0; resp_data=0x3C, resp_id=1.
- req0 data=0x01 amt=7 -> brl_sel sequence 3,3,1; resp_data=0x02; busy high for 4 cycles (3 SHIFT + 1 RESP).
- Both requesters held valid continuously from reset -> grant order 0,1,0,1; req_ready never 11.
- resp_ready held 0 for 5 cycles in RESP -> resp_valid, resp_data and resp_id stable; req_ready=00 throughout; accept only after the resp handshake.
- reset_n pulsed low during the second SHIFT cycle -> all outputs 0 immediately; no response; next grant goes to requester 0. With BARREL_CTRL_LEFT_EN: req0 0x81, left 1 -> resp_data=0x03 via right 7 (sel 3,3,1).
